vec_alpha_pipe: RTL and testbench
=================================

Name: vec_alpha_pipe

Overview:
- Parametrised, multi-lane vector execution pipeline for alpha composition.
- Successor to the fixed 128-bit single-cycle vector ALU path: lanes, pixel width and pipeline depth are generalised.
- Adds composition modes and valid/ready backpressure plus flush, which the current path lacks.
- Sits between the decode/pipeline-mem register and the memory stage. The tag carries the destination vector register index to writeback.

Parameters:
LANES, 16, number of pixel lanes per vector (16 x 8 = 128-bit vector)
PIX_W, 8, bits per pixel/alpha component; MAX = 2^PIX_W-1
STAGES, 3, pipeline depth in register stages; legal range 2..8
TAG_W, 4, sideband tag width (destination register index)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  squash all in-flight beats (taken branch)
in_valid  in  1  input beat valid
in_ready  out  1  pipeline accepts the beat this cycle
in_mode  in  2  0 blend, 1 multiply, 2 saturating add, 3 pass fg
in_fg  in  LANES*PIX_W  foreground vector, lane i at bits [i*PIX_W +: PIX_W]
in_bg  in  LANES*PIX_W  background vector
in_alpha  in  LANES*PIX_W  per-lane alpha
in_tag  in  TAG_W  destination tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_data  out  LANES*PIX_W  result vector
out_tag  out  TAG_W  tag of the result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all stage valid bits 0, out_valid 0, out_data 0, out_tag 0.
- Advance: global pipeline enable adv = out_ready | ~out_valid.
  - in_ready = adv & ~flush.
  - When adv=0, every stage holds its contents.
  - Beat accepted when in_valid & in_ready.
- Latency: exactly STAGES cycles from acceptance to out_valid when adv stays 1. Bubbles are not collapsed. Throughput is one beat per cycle.
- Stage 1 (per lane, registered): products.
  - Blend: p = fg*alpha + bg*(MAX-alpha), 2*PIX_W+1 bits.
  - Multiply: p = fg*bg.
  - Add: s = fg+bg, PIX_W+1 bits.
  - Pass: p = fg.
- Stage 2: normalise.
  - Blend and multiply: t = p + 2^(PIX_W-1); r = (t + (t >> PIX_W)) >> PIX_W. This is exact rounded division by MAX.
  - Add: r = MAX if s > MAX, else s.
  - Pass: r = fg.
- Stages 3..STAGES: pure delay registers carrying valid, tag and data.
- Mode and tag travel with the beat. A mode change between consecutive beats needs no bubble.
- Flush:
  - Synchronous; clears every stage valid and out_valid in the same cycle edge. Data registers are don't-care.
  - A beat presented while flush=1 is dropped (in_ready=0).
  - Flush overrides stall: it applies even when adv=0.
- rst mid-operation: identical to flush, and additionally zeroes out_data and out_tag.
- out_data/out_tag remain stable while out_valid=1 and out_ready=0.
- STAGES outside 2..8: elaboration error via static assertion.

Optional Feature:
- Macro: VEC_ALPHA_PERF_CNT_EN.
- When defined, adds outputs perf_beats[31:0] and perf_stalls[31:0].
  - perf_beats: beats retired, i.e. out_valid & out_ready.
  - perf_stalls: cycles with out_valid & ~out_ready.
  - Both reset to 0 on rst, are not cleared by flush, and wrap modulo 2^32.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package vec_alpha_pkg holds:
  - the alpha_mode_e enum (BLEND=0, MUL=1, ADD_SAT=2, PASS=3);
  - function norm_div_max() for rounded division by MAX.
- Sub-module vec_alpha_lane: one lane's stage-1/stage-2 datapath, with its stage enable driven by the parent.
- The parent generates LANES instances and owns the valid/tag pipeline, handshake, flush and counters.

Test Plan:
- Blend, all lanes fg=200, bg=100 (PIX_W=8):
  - alpha=255 -> 200.
  - alpha=0 -> 100.
  - alpha=128 -> 150.
  - Each result appears STAGES cycles after acceptance with the tag preserved.
- Multiply fg=255, bg=255 -> 255; fg=128, bg=128 -> 64. Saturating add 200+100 -> 255; 10+20 -> 30. Pass fg=0xAB -> 0xAB.
- Back-to-back 8 beats with mixed modes and out_ready=1 -> 8 results in order, with no gaps after the first.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with the pipeline full.
  - Required: in_ready=0, and out_data/out_tag stable.
  - After release, all beats emerge in order with none lost or duplicated.
- Flush with 3 beats in flight plus in_valid=1 -> next cycle all valids are 0 and in_ready was 0, so none of the 4 beats ever appears. Assert rst mid-stream -> out_valid=0 and out_data=0 on the next edge.
- With VEC_ALPHA_PERF_CNT_EN defined: 6 retired beats and 4 stall cycles -> perf_beats=6, perf_stalls=4; flush leaves both unchanged.

Source files
------------

// File: rtl/vec_alpha_pkg.sv
// Shared types and helpers for the vec_alpha_pipe vector composition pipeline.
package vec_alpha_pkg;

   typedef enum logic [1:0] {
      BLEND   = 2'd0,
      MUL     = 2'd1,
      ADD_SAT = 2'd2,
      PASS    = 2'd3
   } alpha_mode_e;

   localparam int MAX_PIX_W = 16;
   localparam int NORM_W    = 2 * MAX_PIX_W + 2;

   // Rounded division by MAX = 2^pixW-1 without a divider: add half, then fold the high part back in.
   function automatic logic [NORM_W-1:0] norm_div_max(input logic [NORM_W-1:0] p, input int pixW);
      logic [NORM_W-1:0] t;
      t = p + (NORM_W'(1) << (pixW - 1));
      return (t + (t >> pixW)) >> pixW;
   endfunction

endpackage

// File: rtl/vec_alpha_lane.sv
// One pixel lane: stage-1 product/sum register and stage-2 normalised result register.
// Both stages advance together on en_i, which the parent drives from the global pipeline enable.
module vec_alpha_lane
   import vec_alpha_pkg::*;
#(
   parameter int PIX_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  alpha_mode_e       modeIn_i,
   input  alpha_mode_e       modeS1_i,
   input  logic [PIX_W-1:0]  fg_i,
   input  logic [PIX_W-1:0]  bg_i,
   input  logic [PIX_W-1:0]  alpha_i,
   output logic [PIX_W-1:0]  res_o
);

   localparam int PW = 2 * PIX_W + 1;
   localparam logic [PIX_W-1:0] MAXV = '1;

   if (PIX_W > MAX_PIX_W) begin : g_badPixW
      $error("vec_alpha_lane: PIX_W exceeds MAX_PIX_W");
   end

   logic [PW-1:0]    prod_d, prod_q;
   logic [PIX_W-1:0] res_d, res_q;

   always_comb begin
      prod_d = '0;
      case (modeIn_i)
         BLEND:   prod_d = PW'(fg_i) * PW'(alpha_i) + PW'(bg_i) * PW'(MAXV - alpha_i);
         MUL:     prod_d = PW'(fg_i) * PW'(bg_i);
         ADD_SAT: prod_d = PW'(fg_i) + PW'(bg_i);
         PASS:    prod_d = PW'(fg_i);
         default: prod_d = '0;
      endcase
   end

   // In pass mode the stage-1 register already holds fg, so its low bits are the result.
   always_comb begin
      res_d = prod_q[PIX_W-1:0];
      case (modeS1_i)
         BLEND, MUL: res_d = PIX_W'(norm_div_max(NORM_W'(prod_q), PIX_W));
         ADD_SAT:    res_d = (prod_q > PW'(MAXV)) ? MAXV : prod_q[PIX_W-1:0];
         default:    res_d = prod_q[PIX_W-1:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q <= '0;
         res_q  <= '0;
      end else if (en_i) begin
         prod_q <= prod_d;
         res_q  <= res_d;
      end
   end

   assign res_o = res_q;

endmodule

// File: rtl/vec_alpha_pipe.sv
// Multi-lane alpha composition pipeline with valid/ready backpressure and flush.
// Optional perf counters (perf_beats, perf_stalls) are built when VEC_ALPHA_PERF_CNT_EN is defined.
module vec_alpha_pipe
   import vec_alpha_pkg::*;
#(
   parameter int LANES  = 16,
   parameter int PIX_W  = 8,
   parameter int STAGES = 3,
   parameter int TAG_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              in_mode,
   input  logic [LANES*PIX_W-1:0]  in_fg,
   input  logic [LANES*PIX_W-1:0]  in_bg,
   input  logic [LANES*PIX_W-1:0]  in_alpha,
   input  logic [TAG_W-1:0]        in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*PIX_W-1:0]  out_data,
   output logic [TAG_W-1:0]        out_tag
`ifdef VEC_ALPHA_PERF_CNT_EN
   ,
   output logic [31:0]             perf_beats,
   output logic [31:0]             perf_stalls
`endif
);

   localparam int DW = LANES * PIX_W;

   if (STAGES < 2 || STAGES > 8) begin : g_badStages
      $error("vec_alpha_pipe: STAGES must be within 2..8");
   end

   logic              adv;
   logic              accept;
   logic [STAGES-1:0] vld_d, vld_q;
   logic [TAG_W-1:0]  tag_q [STAGES];
   alpha_mode_e       modeS1_q;
   logic [DW-1:0]     s2Data;

   // A single enable stalls every stage at once; bubbles travel with the beats.
   assign adv      = out_ready | ~vld_q[STAGES-1];
   assign in_ready = adv & ~flush;
   assign accept   = in_valid & in_ready;
   assign vld_d    = {vld_q[STAGES-2:0], accept};

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         vld_q <= '0;
      end else if (adv) begin
         vld_q <= vld_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         modeS1_q <= BLEND;
         for (int i = 0; i < STAGES; i++) begin
            tag_q[i] <= '0;
         end
      end else if (adv) begin
         modeS1_q <= alpha_mode_e'(in_mode);
         tag_q[0] <= in_tag;
         for (int i = 1; i < STAGES; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      vec_alpha_lane #(
         .PIX_W(PIX_W)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .en_i     (adv),
         .modeIn_i (alpha_mode_e'(in_mode)),
         .modeS1_i (modeS1_q),
         .fg_i     (in_fg[g*PIX_W +: PIX_W]),
         .bg_i     (in_bg[g*PIX_W +: PIX_W]),
         .alpha_i  (in_alpha[g*PIX_W +: PIX_W]),
         .res_o    (s2Data[g*PIX_W +: PIX_W])
      );
   end

   if (STAGES > 2) begin : g_dly
      logic [DW-1:0] dly_q [STAGES-2];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < STAGES - 2; i++) begin
               dly_q[i] <= '0;
            end
         end else if (adv) begin
            dly_q[0] <= s2Data;
            for (int i = 1; i < STAGES - 2; i++) begin
               dly_q[i] <= dly_q[i-1];
            end
         end
      end

      assign out_data = dly_q[STAGES-3];
   end else begin : g_noDly
      assign out_data = s2Data;
   end

   assign out_valid = vld_q[STAGES-1];
   assign out_tag   = tag_q[STAGES-1];

`ifdef VEC_ALPHA_PERF_CNT_EN
   logic [31:0] beats_q, stalls_q;

   // Counters survive flush; only rst clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         beats_q  <= '0;
         stalls_q <= '0;
      end else begin
         if (out_valid && out_ready) begin
            beats_q <= beats_q + 32'd1;
         end
         if (out_valid && !out_ready) begin
            stalls_q <= stalls_q + 32'd1;
         end
      end
   end

   assign perf_beats  = beats_q;
   assign perf_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_vec_alpha_pipe.sv
// Scoreboard bench for vec_alpha_pipe at default parameters (16 lanes x 8 bits, 3 stages).
// Perf counter checks are compiled in when VEC_ALPHA_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module tb_vec_alpha_pipe;
   import vec_alpha_pkg::*;

   localparam int LANES  = 16;
   localparam int PIX_W  = 8;
   localparam int STAGES = 3;
   localparam int TAG_W  = 4;
   localparam int DW     = LANES * PIX_W;

   logic             clk = 1'b0;
   logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [1:0]       in_mode;
   logic [DW-1:0]    in_fg, in_bg, in_alpha, out_data;
   logic [TAG_W-1:0] in_tag, out_tag;
`ifdef VEC_ALPHA_PERF_CNT_EN
   logic [31:0]      perf_beats, perf_stalls;
`endif

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [DW-1:0]    data;
      int               cyc;
      bit               chkLat;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vec_alpha_pipe #(
      .LANES(LANES), .PIX_W(PIX_W), .STAGES(STAGES), .TAG_W(TAG_W)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_fg(in_fg), .in_bg(in_bg), .in_alpha(in_alpha), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag)
`ifdef VEC_ALPHA_PERF_CNT_EN
      , .perf_beats(perf_beats), .perf_stalls(perf_stalls)
`endif
   );

   function automatic logic [DW-1:0] rep(input logic [7:0] v);
      return {LANES{v}};
   endfunction

   function automatic logic [DW-1:0] alt(input logic [7:0] ev, input logic [7:0] od);
      logic [DW-1:0] v;
      for (int i = 0; i < LANES; i++) v[i*PIX_W +: PIX_W] = (i % 2 == 0) ? ev : od;
      return v;
   endfunction

   function automatic logic [DW-1:0] ramp();
      logic [DW-1:0] v;
      for (int i = 0; i < LANES; i++) v[i*PIX_W +: PIX_W] = 8'(i * 17);
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic checkSmall(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one beat and push its expected result once the DUT accepts it.
   task automatic applyStimulus(input logic [1:0] mode, input logic [DW-1:0] fg, input logic [DW-1:0] bg,
                                input logic [DW-1:0] alpha, input logic [TAG_W-1:0] tag,
                                input logic [DW-1:0] expData, input bit chkLat);
      bit done = 1'b0;
      in_valid = 1'b1;
      in_mode  = mode;
      in_fg    = fg;
      in_bg    = bg;
      in_alpha = alpha;
      in_tag   = tag;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_t e;
            e.tag    = tag;
            e.data   = expData;
            e.cyc    = cyc;
            e.chkLat = chkLat;
            expQ.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      checkSmall("accept within 50 cycles", int'(done), 1);
   endtask

   task automatic drain();
      int n = 0;
      while (expQ.size() != 0 && n < 100) begin
         tick(1);
         n++;
      end
      checkSmall("scoreboard drained", expQ.size(), 0);
      tick(2);
   endtask

   // Fill the pipe with out_ready low, hold it for n stall cycles, then release and add three more beats.
   task automatic stallSeg(input int n, input logic [TAG_W-1:0] t0);
      out_ready = 1'b0;
      applyStimulus(ADD_SAT, rep(8'd200), rep(8'd100), '0, t0, rep(8'd255), 1'b0);
      applyStimulus(MUL, rep(8'd128), rep(8'd128), '0, t0 + 4'd1, rep(8'd64), 1'b0);
      applyStimulus(PASS, rep(8'h5A), '0, '0, t0 + 4'd2, rep(8'h5A), 1'b0);
      repeat (n) begin
         @(negedge clk);
         checkSmall("stall in_ready", int'(in_ready), 0);
         checkSmall("stall out_valid", int'(out_valid), 1);
         checkOutput("stall out_data", out_data, rep(8'd255));
         checkSmall("stall out_tag", int'(out_tag), int'(t0));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      applyStimulus(ADD_SAT, rep(8'd10), rep(8'd20), '0, t0 + 4'd3, rep(8'd30), 1'b1);
      applyStimulus(BLEND, rep(8'd200), rep(8'd100), rep(8'd0), t0 + 4'd4, rep(8'd100), 1'b1);
      applyStimulus(PASS, rep(8'h11), rep(8'h22), '0, t0 + 4'd5, rep(8'h11), 1'b1);
      drain();
   endtask

   // Monitor: every retired beat must match the head of the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected beat: tag %h data %h, required no output", out_tag, out_data);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               checkSmall("out_tag", int'(out_tag), int'(e.tag));
               checkOutput("out_data", out_data, e.data);
               if (e.chkLat) checkSmall("latency", cyc - e.cyc, STAGES);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mode = '0;
      in_fg = '0; in_bg = '0; in_alpha = '0; in_tag = '0; out_ready = 1'b1;
      tick(3);
      @(negedge clk);
      checkSmall("reset out_valid", int'(out_valid), 0);
      checkOutput("reset out_data", out_data, '0);
      checkSmall("reset out_tag", int'(out_tag), 0);
`ifdef VEC_ALPHA_PERF_CNT_EN
      checkSmall("reset perf_beats", int'(perf_beats), 0);
      checkSmall("reset perf_stalls", int'(perf_stalls), 0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkSmall("idle in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;

      $display("[TB] blend");
      applyStimulus(BLEND, rep(8'd200), rep(8'd100), rep(8'd255), 4'h1, rep(8'd200), 1'b1);
      applyStimulus(BLEND, rep(8'd200), rep(8'd100), rep(8'd0),   4'h2, rep(8'd100), 1'b1);
      applyStimulus(BLEND, rep(8'd200), rep(8'd100), rep(8'd128), 4'h3, rep(8'd150), 1'b1);
      drain();

      $display("[TB] multiply / add / pass");
      applyStimulus(MUL, rep(8'd255), rep(8'd255), '0, 4'h4, rep(8'd255), 1'b1);
      applyStimulus(MUL, rep(8'd128), rep(8'd128), '0, 4'h5, rep(8'd64), 1'b1);
      applyStimulus(ADD_SAT, rep(8'd200), rep(8'd100), '0, 4'h6, rep(8'd255), 1'b1);
      applyStimulus(ADD_SAT, rep(8'd10), rep(8'd20), '0, 4'h7, rep(8'd30), 1'b1);
      applyStimulus(PASS, rep(8'hAB), rep(8'hCD), rep(8'h12), 4'h8, rep(8'hAB), 1'b1);
      applyStimulus(BLEND, rep(8'd200), rep(8'd100), alt(8'd255, 8'd0), 4'h9, alt(8'd200, 8'd100), 1'b1);
      applyStimulus(PASS, ramp(), '0, '0, 4'hA, ramp(), 1'b1);
      drain();

      $display("[TB] back-to-back mixed modes");
      applyStimulus(BLEND, rep(8'd0), rep(8'd255), rep(8'd255), 4'h0, rep(8'd0), 1'b1);
      applyStimulus(MUL, rep(8'd255), rep(8'd0), '0, 4'h1, rep(8'd0), 1'b1);
      applyStimulus(ADD_SAT, rep(8'd255), rep(8'd255), '0, 4'h2, rep(8'd255), 1'b1);
      applyStimulus(PASS, rep(8'hFF), rep(8'h00), '0, 4'h3, rep(8'hFF), 1'b1);
      applyStimulus(BLEND, rep(8'd10), rep(8'd250), rep(8'd51), 4'h4, rep(8'd202), 1'b1);
      applyStimulus(MUL, rep(8'd100), rep(8'd200), '0, 4'h5, rep(8'd78), 1'b1);
      applyStimulus(ADD_SAT, rep(8'd127), rep(8'd128), '0, 4'h6, rep(8'd255), 1'b1);
      applyStimulus(ADD_SAT, rep(8'd0), rep(8'd0), '0, 4'h7, rep(8'd0), 1'b1);
      drain();

      $display("[TB] backpressure");
      stallSeg(5, 4'h1);

      $display("[TB] reset mid-stream");
      out_ready = 1'b0;
      applyStimulus(ADD_SAT, rep(8'd200), rep(8'd100), '0, 4'hB, rep(8'd255), 1'b0);
      applyStimulus(PASS, rep(8'h33), '0, '0, 4'hC, rep(8'h33), 1'b0);
      applyStimulus(PASS, rep(8'h44), '0, '0, 4'hD, rep(8'h44), 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      expQ.delete();
      @(negedge clk);
      checkSmall("rst out_valid", int'(out_valid), 0);
      checkOutput("rst out_data", out_data, '0);
      checkSmall("rst out_tag", int'(out_tag), 0);
`ifdef VEC_ALPHA_PERF_CNT_EN
      checkSmall("rst perf_beats", int'(perf_beats), 0);
      checkSmall("rst perf_stalls", int'(perf_stalls), 0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      tick(1);

      $display("[TB] counted stall segment");
      stallSeg(4, 4'h8);
`ifdef VEC_ALPHA_PERF_CNT_EN
      checkSmall("perf_beats after 6 retired", int'(perf_beats), 6);
      checkSmall("perf_stalls after 4 stalls", int'(perf_stalls), 4);
`endif

      $display("[TB] flush");
      out_ready = 1'b0;
      applyStimulus(PASS, rep(8'h01), '0, '0, 4'h2, rep(8'h01), 1'b0);
      applyStimulus(PASS, rep(8'h02), '0, '0, 4'h3, rep(8'h02), 1'b0);
      applyStimulus(PASS, rep(8'h03), '0, '0, 4'h4, rep(8'h03), 1'b0);
      flush = 1'b1;
      in_valid = 1'b1;
      in_mode = PASS;
      in_fg = rep(8'h04);
      in_tag = 4'h5;
      @(negedge clk);
      checkSmall("flush in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      expQ.delete();
      @(negedge clk);
      checkSmall("flush out_valid", int'(out_valid), 0);
`ifdef VEC_ALPHA_PERF_CNT_EN
      // The flush cycle itself still held a valid result with out_ready low, so it counts as one stall.
      checkSmall("flush perf_beats", int'(perf_beats), 6);
      checkSmall("flush perf_stalls", int'(perf_stalls), 5);
`endif
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      tick(8);
`ifdef VEC_ALPHA_PERF_CNT_EN
      checkSmall("post-flush perf_beats", int'(perf_beats), 6);
      checkSmall("post-flush perf_stalls", int'(perf_stalls), 5);
`endif

      $display("[TB] beat after flush");
      applyStimulus(BLEND, rep(8'd200), rep(8'd100), rep(8'd128), 4'hE, rep(8'd150), 1'b1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
